// File: rtl/pipe_datapath.sv
// Three-stage X/M/W datapath with operand forwarding into the X-stage operand outputs.
// Define DATAPATH_FWD_EN to build the M/W forwarding network; otherwise operands pass straight through.
module pipe_datapath #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_RES = 4,
  parameter int unsigned RADDR_W = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      d_valid_i,
  input  logic [RADDR_W-1:0]        rs1_addr_i,
  input  logic [RADDR_W-1:0]        rs2_addr_i,
  input  logic [RADDR_W-1:0]        rd_addr_i,
  input  logic                      rd_we_i,
  input  logic [XLEN-1:0]           reg1_data_i,
  input  logic [XLEN-1:0]           reg2_data_i,
  input  logic [XLEN-1:0]           pc_val_d2_i,
  input  logic [XLEN-1:0]           imm_signed_i,
  input  logic                      x_op1_sel_i,
  input  logic                      x_op2_sel_i,
  input  logic [NUM_RES*XLEN-1:0]   res_i,
  input  logic [$clog2(NUM_RES)-1:0] res_sel_i,
  output logic [XLEN-1:0]           x_op1_o,
  output logic [XLEN-1:0]           x_op2_o,
  output logic                      x_valid_o,
  output logic [XLEN-1:0]           m_alu_data_o,
  output logic                      m_valid_o,
  output logic [XLEN-1:0]           w_data_o,
  output logic [RADDR_W-1:0]        w_rd_addr_o,
  output logic                      w_we_o
);

  localparam int unsigned SelW = $clog2(NUM_RES);

  logic               r_x_valid, r_x_we;
  logic [RADDR_W-1:0] r_x_rd;
  logic [XLEN-1:0]    r_x_op1, r_x_op2;
  logic               r_m_valid, r_m_we;
  logic [RADDR_W-1:0] r_m_rd;
  logic [XLEN-1:0]    r_m_data;
  logic               r_w_valid, r_w_we;
  logic [RADDR_W-1:0] r_w_rd;
  logic [XLEN-1:0]    r_w_data;

  logic [XLEN-1:0]    w_res_data;
  logic [XLEN-1:0]    w_x_op1, w_x_op2;
  logic               w_advance;

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_res_data = '0;
    for (int unsigned k = 0; k < NUM_RES; k++) begin
      if (res_sel_i == SelW'(k)) w_res_data = res_i[k*XLEN +: XLEN];
    end
  end

  assign w_advance = flush_i || !stall_i;

`ifdef DATAPATH_FWD_EN
  logic [RADDR_W-1:0] r_x_rs1, r_x_rs2;
  logic               r_x_sel1, r_x_sel2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x_rs1  <= '0;
      r_x_rs2  <= '0;
      r_x_sel1 <= 1'b0;
      r_x_sel2 <= 1'b0;
    end else if (w_advance) begin
      r_x_rs1  <= rs1_addr_i;
      r_x_rs2  <= rs2_addr_i;
      r_x_sel1 <= x_op1_sel_i;
      r_x_sel2 <= x_op2_sel_i;
    end
  end

  // M is younger than W, so it wins when both hold the same destination.
  always_comb begin
    w_x_op1 = r_x_op1;
    w_x_op2 = r_x_op2;
    if (!r_x_sel1 && (r_x_rs1 != '0)) begin
      if (r_m_valid && r_m_we && (r_m_rd == r_x_rs1))      w_x_op1 = r_m_data;
      else if (r_w_valid && r_w_we && (r_w_rd == r_x_rs1)) w_x_op1 = r_w_data;
    end
    if (!r_x_sel2 && (r_x_rs2 != '0)) begin
      if (r_m_valid && r_m_we && (r_m_rd == r_x_rs2))      w_x_op2 = r_m_data;
      else if (r_w_valid && r_w_we && (r_w_rd == r_x_rs2)) w_x_op2 = r_w_data;
    end
  end
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{rs1_addr_i, rs2_addr_i};
  assign w_x_op1     = r_x_op1;
  assign w_x_op2     = r_x_op2;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x_valid <= 1'b0;
      r_x_we    <= 1'b0;
      r_x_rd    <= '0;
      r_x_op1   <= '0;
      r_x_op2   <= '0;
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_rd    <= '0;
      r_m_data  <= '0;
      r_w_valid <= 1'b0;
      r_w_we    <= 1'b0;
      r_w_rd    <= '0;
      r_w_data  <= '0;
    end else if (w_advance) begin
      // Flush kills the instructions entering X and M; W still retires M.
      r_x_valid <= d_valid_i && !flush_i;
      r_x_we    <= rd_we_i;
      r_x_rd    <= rd_addr_i;
      r_x_op1   <= x_op1_sel_i ? pc_val_d2_i : reg1_data_i;
      r_x_op2   <= x_op2_sel_i ? imm_signed_i : reg2_data_i;
      r_m_valid <= r_x_valid && !flush_i;
      r_m_we    <= r_x_we;
      r_m_rd    <= r_x_rd;
      r_m_data  <= w_res_data;
      r_w_valid <= r_m_valid;
      r_w_we    <= r_m_we;
      r_w_rd    <= r_m_rd;
      r_w_data  <= r_m_data;
    end
  end

  assign x_op1_o      = w_x_op1;
  assign x_op2_o      = w_x_op2;
  assign x_valid_o    = r_x_valid;
  assign m_alu_data_o = r_m_data;
  assign m_valid_o    = r_m_valid;
  assign w_data_o     = r_w_data;
  assign w_rd_addr_o  = r_w_rd;
  assign w_we_o       = r_w_valid && r_w_we;

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath: directed hazard/stall/flush/reset cases, then random traffic.
module tb_pipe_datapath;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NRES = 4;
  localparam int unsigned RAW  = 5;

`ifdef DATAPATH_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, stall, flush, d_valid, we, sel1, sel2;
  logic [RAW-1:0]       rs1, rs2, rd;
  logic [XLEN-1:0]      reg1, reg2, pc, imm;
  logic [NRES*XLEN-1:0] res;
  logic [1:0]           res_sel;
  logic [XLEN-1:0]      x_op1, x_op2, m_data, w_data;
  logic                 x_valid, m_valid, w_we;
  logic [RAW-1:0]       w_rd;

  pipe_datapath #(.XLEN(XLEN), .NUM_RES(NRES), .RADDR_W(RAW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .d_valid_i(d_valid),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rd_addr_i(rd), .rd_we_i(we),
    .reg1_data_i(reg1), .reg2_data_i(reg2), .pc_val_d2_i(pc), .imm_signed_i(imm),
    .x_op1_sel_i(sel1), .x_op2_sel_i(sel2), .res_i(res), .res_sel_i(res_sel),
    .x_op1_o(x_op1), .x_op2_o(x_op2), .x_valid_o(x_valid), .m_alu_data_o(m_data),
    .m_valid_o(m_valid), .w_data_o(w_data), .w_rd_addr_o(w_rd), .w_we_o(w_we)
  );

  // One in-flight instruction as the reference model sees it.
  typedef struct {
    logic            v, we, s1, s2;
    logic [RAW-1:0]  rd, rs1, rs2;
    logic [XLEN-1:0] a, b, data;
  } ins_t;

  typedef struct {
    logic            exact, xv, mv, wwe;
    logic [XLEN-1:0] x1, x2, md, wd;
    logic [RAW-1:0]  wrd;
  } exp_t;

  ins_t in_x, in_m, in_w;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest older writer of rs wins; r0 and PC/immediate operands are never replaced.
  function automatic logic [XLEN-1:0] resolve(input logic sel, input logic [RAW-1:0] rs,
                                              input logic [XLEN-1:0] raw);
    ins_t older[2];
    older[0] = in_m;
    older[1] = in_w;
    if (!Fwd || sel || rs == 0) return raw;
    foreach (older[i]) if (older[i].v && older[i].we && older[i].rd == rs) return older[i].data;
    return raw;
  endfunction

  task automatic tick();
    ins_t d;
    exp_t e;
    @(posedge clk);
    d = '{v: d_valid && !flush, we: we, s1: sel1, s2: sel2, rd: rd, rs1: rs1, rs2: rs2,
          a: sel1 ? pc : reg1, b: sel2 ? imm : reg2, data: '0};
    if (rst) begin
      in_x = '{default: '0}; in_m = '{default: '0}; in_w = '{default: '0};
    end else if (flush || !stall) begin
      in_w      = in_m;
      in_m      = in_x;
      in_m.v    = in_x.v && !flush;
      in_m.data = (res_sel < NRES) ? res[res_sel*XLEN +: XLEN] : '0;
      in_x      = d;
    end
    #1;
    e.exact = rst;
    e.xv  = in_x.v;
    e.x1  = resolve(in_x.s1, in_x.rs1, in_x.a);
    e.x2  = resolve(in_x.s2, in_x.rs2, in_x.b);
    e.mv  = in_m.v;
    e.md  = in_m.data;
    e.wwe = in_w.v && in_w.we;
    e.wd  = in_w.data;
    e.wrd = in_w.rd;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("x_valid", {31'b0, x_valid}, {31'b0, e.xv});
      chk("m_valid", {31'b0, m_valid}, {31'b0, e.mv});
      chk("w_we", {31'b0, w_we}, {31'b0, e.wwe});
      if (e.exact || e.xv) begin
        chk("x_op1", x_op1, e.x1);
        chk("x_op2", x_op2, e.x2);
      end
      if (e.exact || e.mv) chk("m_data", m_data, e.md);
      if (e.exact || e.wwe) begin
        chk("w_data", w_data, e.wd);
        chk("w_rd", {27'b0, w_rd}, {27'b0, e.wrd});
      end
    end
  end

  task automatic idle();
    rst = 0; stall = 0; flush = 0; d_valid = 0; we = 0; sel1 = 0; sel2 = 0;
    rs1 = 0; rs2 = 0; rd = 0; reg1 = 0; reg2 = 0; pc = 0; imm = 0; res = '0; res_sel = 0;
  endtask

  task automatic issue(input logic [RAW-1:0] r_d, input logic w, input logic [RAW-1:0] r_s1,
                       input logic [XLEN-1:0] r0_res);
    d_valid = 1; rd = r_d; we = w; rs1 = r_s1; rs2 = 0; reg1 = 0; reg2 = 0;
    sel1 = 0; sel2 = 0; res_sel = 0; res[XLEN-1:0] = r0_res;
    tick();
  endtask

  task automatic randomize_inputs();
    rst = ($urandom_range(0, 99) < 2); stall = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 7); d_valid = ($urandom_range(0, 3) != 0);
    we = $urandom_range(0, 1); sel1 = ($urandom_range(0, 3) == 0); sel2 = ($urandom_range(0, 3) == 0);
    rs1 = RAW'($urandom_range(0, 7)); rs2 = RAW'($urandom_range(0, 7)); rd = RAW'($urandom_range(0, 7));
    reg1 = $urandom; reg2 = $urandom; pc = $urandom; imm = $urandom;
    for (int k = 0; k < NRES; k++) res[k*XLEN +: XLEN] = $urandom;
    res_sel = 2'($urandom_range(0, NRES - 1));
  endtask

  initial begin
    in_x = '{default: '0}; in_m = '{default: '0}; in_w = '{default: '0};
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_w_data", w_data, 32'h0);

    // Back-to-back RAW through M.
    issue(5, 1, 0, 32'h0);
    issue(0, 0, 5, 32'h11);
    chk("raw_m_fwd", x_op1, Fwd ? 32'h11 : 32'h0);

    // Two writers in flight: newest (M) wins.
    issue(5, 1, 0, 32'h0);
    issue(5, 1, 0, 32'h22);
    issue(0, 0, 5, 32'h33);
    chk("m_over_w", x_op1, Fwd ? 32'h33 : 32'h0);

    // Bubble between writer and reader: value comes from W.
    issue(5, 1, 0, 32'h0);
    d_valid = 0; res[XLEN-1:0] = 32'h22; tick();
    issue(0, 0, 5, 32'h99);
    chk("w_fwd", x_op1, Fwd ? 32'h22 : 32'h0);

    // r0 is never forwarded.
    issue(0, 1, 0, 32'h0);
    issue(0, 0, 0, 32'hFFFF);
    chk("r0_rule", x_op1, 32'h0);

    // Stall holds everything, then flush with stall kills X/M and retires M into W.
    issue(6, 1, 0, 32'h0);
    issue(6, 1, 0, 32'hA1);
    issue(6, 1, 0, 32'hA2);
    stall = 1; res[XLEN-1:0] = 32'hA3; tick(); tick();
    chk("stall_m_data", m_data, 32'hA2);
    chk("stall_w_data", w_data, 32'hA1);
    flush = 1; tick();
    chk("flush_x_valid", {31'b0, x_valid}, 32'h0);
    chk("flush_m_valid", {31'b0, m_valid}, 32'h0);
    chk("flush_w_we", {31'b0, w_we}, 32'h1);
    chk("flush_w_data", w_data, 32'hA2);
    idle();

    // Reset with three valid instructions in flight.
    issue(7, 1, 0, 32'h0);
    issue(7, 1, 0, 32'h55);
    issue(7, 1, 0, 32'h66);
    rst = 1; stall = 1; flush = 1; tick();
    chk("rst_x_op1", x_op1, 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_w_we", {31'b0, w_we}, 32'h0);
    chk("rst_w_rd", {27'b0, w_rd}, 32'h0);
    idle();

    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      tick();
    end
    idle();
    tick(); tick();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
